// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-master arbiter for a single-port SRAM with bounded ownership streaks
module sram_port_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic              sram_clken,
  output logic [3:0]        sram_byteenable,
  output logic [31:0]       sram_writedata,
  input  logic [31:0]       sram_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  logic req0, req1;
  logic grant_vld, grant_id;
  logic sel_write, sel_read;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Winner depends only on requests and registered state, never on waitrequest.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        grant_vld = 1'b1;
        case (state_q)
          OWN0:    grant_id = (hold_cnt_q < HOLD_MAX_C) ? 1'b0 : 1'b1;
          OWN1:    grant_id = (hold_cnt_q < HOLD_MAX_C) ? 1'b1 : 1'b0;
          default: grant_id = 1'b0;
        endcase
      end else if (req0) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign sel_write = grant_id ? m1_write : m0_write;
  assign sel_read  = grant_id ? m1_read  : m0_read;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rd_pend_d  = grant_vld && sel_read && !sel_write;
    rd_id_d    = grant_id;
    if (!grant_vld) begin
      state_d    = IDLE;
      hold_cnt_d = 4'd0;
    end else if ((state_q == OWN0 && !grant_id) || (state_q == OWN1 && grant_id)) begin
      hold_cnt_d = (hold_cnt_q >= HOLD_MAX_C) ? HOLD_MAX_C : hold_cnt_q + 4'd1;
    end else begin
      state_d    = grant_id ? OWN1 : OWN0;
      hold_cnt_d = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign m0_waitrequest = !(grant_vld && !grant_id);
  assign m1_waitrequest = !(grant_vld && grant_id);

  assign sram_clken      = 1'b1;
  assign sram_chipselect = grant_vld;
  assign sram_write      = grant_vld && sel_write;
  assign sram_address    = !grant_vld ? '0    : (grant_id ? m1_address    : m0_address);
  assign sram_byteenable = !grant_vld ? 4'h0  : (grant_id ? m1_byteenable : m0_byteenable);
  assign sram_writedata  = !grant_vld ? 32'h0 : (grant_id ? m1_writedata  : m0_writedata);

  // A response still in flight when reset arrives is suppressed, not delivered.
  assign m0_readdatavalid = rd_pend_q && !rd_id_q && !reset;
  assign m1_readdatavalid = rd_pend_q &&  rd_id_q && !reset;
  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized bench for sram_port_arbiter against a behavioural model
module tb_sram_port_arbiter;
  localparam int HOLD = 4;
  localparam int AW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_writedata, m1_writedata;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic          m0_waitrequest, m1_waitrequest;
  logic [31:0]   m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] sram_address;
  logic          sram_chipselect, sram_write, sram_clken;
  logic [3:0]    sram_byteenable;
  logic [31:0]   sram_writedata, sram_readdata;

  sram_port_arbiter #(.HOLD_MAX(HOLD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_clken(sram_clken), .sram_byteenable(sram_byteenable), .sram_writedata(sram_writedata),
    .sram_readdata(sram_readdata)
  );

  // SRAM device: one-cycle registered read
  logic [31:0] mem [0:65535] = '{default: 32'h0};
  logic [31:0] env_rd_q = 32'h0;
  always @(posedge clk) begin
    if (sram_chipselect) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
      end else begin
        env_rd_q <= mem[sram_address];
      end
    end
  end
  assign sram_readdata = env_rd_q;

  // behavioural model: who owns the port, how long the streak is, what read is due
  int          owner = -1;
  int          streak = 0;
  bit          pend = 1'b0;
  int          pend_id = 0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] shadow [0:65535] = '{default: 32'h0};

  int n_tests = 0;
  int n_fail  = 0;

  int          s_win;
  logic        s_wait0, s_wait1, s_cs, s_wr, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    int          w;
    logic        r0, r1, ev0, ev1, ewr;
    logic [AW-1:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    #1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset)              w = -1;
    else if (r0 && r1)      w = (owner < 0) ? 0 : ((streak < HOLD) ? owner : 1 - owner);
    else if (r0)            w = 0;
    else if (r1)            w = 1;
    else                    w = -1;
    ewr = (w == 0) ? m0_write      : (w == 1) ? m1_write      : 1'b0;
    ea  = (w == 0) ? m0_address    : (w == 1) ? m1_address    : '0;
    ebe = (w == 0) ? m0_byteenable : (w == 1) ? m1_byteenable : 4'h0;
    ewd = (w == 0) ? m0_writedata  : (w == 1) ? m1_writedata  : 32'h0;
    ev0 = !reset && pend && pend_id == 0;
    ev1 = !reset && pend && pend_id == 1;
    check("wait0", 32'(m0_waitrequest), 32'(w != 0));
    check("wait1", 32'(m1_waitrequest), 32'(w != 1));
    check("chipselect", 32'(sram_chipselect), 32'(w >= 0));
    check("sram_write", 32'(sram_write), 32'(ewr));
    check("sram_address", 32'(sram_address), 32'(ea));
    check("sram_byteenable", 32'(sram_byteenable), 32'(ebe));
    check("sram_writedata", sram_writedata, ewd);
    check("clken", 32'(sram_clken), 32'd1);
    check("rdvalid0", 32'(m0_readdatavalid), 32'(ev0));
    check("rdvalid1", 32'(m1_readdatavalid), 32'(ev1));
    if (ev0) check("readdata0", m0_readdata, pend_data);
    if (ev1) check("readdata1", m1_readdata, pend_data);
    s_win   = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
    s_wait0 = m0_waitrequest;   s_wait1 = m1_waitrequest;
    s_cs    = sram_chipselect;  s_wr    = sram_write;
    s_rv0   = m0_readdatavalid; s_rv1   = m1_readdatavalid;
    s_rd0   = m0_readdata;      s_rd1   = m1_readdata;
    @(posedge clk);
    if (reset) begin
      owner = -1; streak = 0; pend = 1'b0;
    end else begin
      pend = 1'b0;
      if (w >= 0) begin
        if (ewr) shadow[ea] = merge(shadow[ea], ewd, ebe);
        else begin
          pend = 1'b1; pend_id = w; pend_data = shadow[ea];
        end
      end
      if (w < 0)            begin owner = -1; streak = 0; end
      else if (w == owner)  streak = (streak + 1 > HOLD) ? HOLD : streak + 1;
      else                  begin owner = w; streak = 1; end
    end
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic m0_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = 4'hF;
  endtask

  task automatic m1_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = 4'hF;
  endtask

  int exp35 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1;
    m0_req(1, 0, 16'h0001, 32'h0); m1_req(1, 0, 16'h0002, 32'h0);
    step();
    check("rst_wait0", 32'(s_wait0), 32'd1);
    check("rst_wait1", 32'(s_wait1), 32'd1);
    check("rst_cs", 32'(s_cs), 32'd0);
    step();
    reset = 1'b0; idle();
    step();

    m0_req(0, 1, 16'h0010, 32'hDEADBEEF);
    step();
    check("s034_wr_grant", 32'(s_win), 32'd0);
    check("s034_wr_write", 32'(s_wr), 32'd1);
    m0_req(1, 0, 16'h0010, 32'h0);
    step();
    check("s034_rd_grant", 32'(s_win), 32'd0);
    idle();
    step();
    check("s034_valid", 32'(s_rv0), 32'd1);
    check("s034_data", s_rd0, 32'hDEADBEEF);

    m0_req(1, 0, 16'h0010, 32'h0); m1_req(1, 0, 16'h0010, 32'h0);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("s035_grant%0d", i), 32'(s_win), 32'(exp35[i]));
    end
    idle(); step();

    m0_req(0, 1, 16'h0020, 32'hA5A5A5A5); step();
    idle(); m1_req(0, 1, 16'h0021, 32'h5A5A5A5A); step();
    idle(); step();
    m0_req(1, 0, 16'h0020, 32'h0); step();
    idle(); m1_req(1, 0, 16'h0021, 32'h0); step();
    check("s036_valid0", 32'(s_rv0), 32'd1);
    check("s036_data0", s_rd0, 32'hA5A5A5A5);
    check("s036_novalid1", 32'(s_rv1), 32'd0);
    idle(); step();
    check("s036_valid1", 32'(s_rv1), 32'd1);
    check("s036_data1", s_rd1, 32'h5A5A5A5A);
    check("s036_novalid0", 32'(s_rv0), 32'd0);

    m0_req(1, 0, 16'h0003, 32'h0); step(); step();
    m0_read = 0; m1_req(1, 0, 16'h0004, 32'h0); step();
    check("s037_switch", 32'(s_win), 32'd1);
    m0_read = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s037_hold%0d", i), 32'(s_win), 32'd1);
    end
    step();
    check("s037_handback", 32'(s_win), 32'd0);
    idle(); step();

    m1_req(1, 0, 16'h0021, 32'h0); step();
    check("s038_grant", 32'(s_win), 32'd1);
    idle(); reset = 1'b1; step();
    check("s038_novalid_rst", 32'(s_rv1), 32'd0);
    reset = 1'b0; step();
    check("s038_novalid_after", 32'(s_rv1), 32'd0);
    m0_req(1, 0, 16'h0005, 32'h0); m1_req(1, 0, 16'h0006, 32'h0); step();
    check("s038_idle_prio", 32'(s_win), 32'd0);
    idle(); step();

    m0_req(1, 1, 16'h0030, 32'h12345678); step();
    check("s039_write", 32'(s_wr), 32'd1);
    idle(); step();
    check("s039_novalid0", 32'(s_rv0), 32'd0);
    check("s039_novalid1", 32'(s_rv1), 32'd0);
    m0_req(1, 0, 16'h0030, 32'h0); step();
    idle(); step();
    check("s039_data", s_rd0, 32'h12345678);

    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 127) == 0);
      m0_read       = ($urandom_range(0, 2) != 0);
      m0_write      = ($urandom_range(0, 3) == 0);
      m1_read       = ($urandom_range(0, 2) != 0);
      m1_write      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin m0_read = 0; m0_write = 0; end
      if ($urandom_range(0, 3) == 0) begin m1_read = 0; m1_write = 0; end
      m0_address    = 16'($urandom_range(0, 63));
      m1_address    = 16'($urandom_range(0, 63));
      m0_writedata  = $urandom;
      m1_writedata  = $urandom;
      m0_byteenable = 4'($urandom_range(0, 15));
      m1_byteenable = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
